zap_alu_pipe: RTL and testbench



---
 rtl/zap_alu_pkg.sv | 70 +++++++
 rtl/zap_alu_iter_mul.sv | 57 +++++
 rtl/zap_alu_pipe.sv | 192 +++++++++++++++++++
 tb/tb_zap_alu_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_alu_pkg.sv
// zap_alu_pkg: shared encodings for the ZAP execute-stage ALU.
// Opcodes, condition codes, flag indices, FSM states, cc evaluation.
`timescale 1ns/1ps
package zap_alu_pkg;

  typedef enum logic [4:0] {
    OP_AND = 5'd0,  OP_EOR = 5'd1,  OP_SUB = 5'd2,  OP_RSB = 5'd3,
    OP_ADD = 5'd4,  OP_ADC = 5'd5,  OP_SBC = 5'd6,  OP_RSC = 5'd7,
    OP_TST = 5'd8,  OP_TEQ = 5'd9,  OP_CMP = 5'd10, OP_CMN = 5'd11,
    OP_ORR = 5'd12, OP_MOV = 5'd13, OP_BIC = 5'd14, OP_MVN = 5'd15,
    OP_MUL = 5'd16, OP_MLA = 5'd17
  } op_t;

  localparam logic [3:0] CC_EQ = 4'd0;
  localparam logic [3:0] CC_NE = 4'd1;
  localparam logic [3:0] CC_CS = 4'd2;
  localparam logic [3:0] CC_CC = 4'd3;
  localparam logic [3:0] CC_MI = 4'd4;
  localparam logic [3:0] CC_PL = 4'd5;
  localparam logic [3:0] CC_VS = 4'd6;
  localparam logic [3:0] CC_VC = 4'd7;
  localparam logic [3:0] CC_HI = 4'd8;
  localparam logic [3:0] CC_LS = 4'd9;
  localparam logic [3:0] CC_GE = 4'd10;
  localparam logic [3:0] CC_LT = 4'd11;
  localparam logic [3:0] CC_GT = 4'd12;
  localparam logic [3:0] CC_LE = 4'd13;
  localparam logic [3:0] CC_AL = 4'd14;
  localparam logic [3:0] CC_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  function automatic logic cond_pass(
    input logic [3:0] cc,
    input logic [3:0] f
  );
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cc)
      CC_EQ:   cond_pass = z;
      CC_NE:   cond_pass = !z;
      CC_CS:   cond_pass = c;
      CC_CC:   cond_pass = !c;
      CC_MI:   cond_pass = n;
      CC_PL:   cond_pass = !n;
      CC_VS:   cond_pass = v;
      CC_VC:   cond_pass = !v;
      CC_HI:   cond_pass = c && !z;
      CC_LS:   cond_pass = !c || z;
      CC_GE:   cond_pass = (n == v);
      CC_LT:   cond_pass = (n != v);
      CC_GT:   cond_pass = !z && (n == v);
      CC_LE:   cond_pass = z || (n != v);
      CC_AL:   cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/zap_alu_iter_mul.sv
// zap_alu_iter_mul: iterative multiplier, MUL_STEP multiplier bits per cycle.
// Result is combinational so the final step lands in the output register.
`timescale 1ns/1ps
module zap_alu_iter_mul #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  input  logic [WIDTH-1:0] acc_init,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int STEPS = WIDTH / MUL_STEP;
  localparam int CNT_W = $clog2(STEPS + 1);

  logic [CNT_W-1:0]          count;
  logic [WIDTH-1:0]          acc;
  logic [WIDTH-1:0]          cand;
  logic [WIDTH-1:0]          plier;
  logic [WIDTH+MUL_STEP-1:0] pp;

  assign pp = {{MUL_STEP{1'b0}}, cand}
            * {{WIDTH{1'b0}}, plier[MUL_STEP-1:0]};

  assign result = acc + pp[WIDTH-1:0];
  assign done   = run && (count == CNT_W'(STEPS - 1));

  // Load operands on start, then retire one multiplier chunk per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc   <= '0;
      cand  <= '0;
      plier <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= '0;
      acc   <= acc_init;
      cand  <= mcand;
      plier <= mplier;
    end else if (run) begin
      acc   <= result;
      cand  <= cand << MUL_STEP;
      plier <= plier >> MUL_STEP;
      count <= done ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/zap_alu_pipe.sv
// zap_alu_pipe: width-generic execute-stage ALU with NZCV flags,
// condition check, valid/ready handshake and iterative MUL/MLA.
`timescale 1ns/1ps
module zap_alu_pipe
  import zap_alu_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  PHY_REGS = 46,
  parameter int  PC_INDEX = 15,
  parameter int  MUL_STEP = 4,
  localparam int IDX_W    = $clog2(PHY_REGS)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_clear,
  input  logic [3:0]       i_clear_flags,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_op,
  input  logic [3:0]       i_cc,
  input  logic             i_flag_update,
  input  logic             i_rrx,
  input  logic             i_shift_carry,
  input  logic [WIDTH-1:0] i_rn,
  input  logic [WIDTH-1:0] i_rm,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [IDX_W-1:0] i_dest_index,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [IDX_W-1:0] o_dest_index,
  output logic             o_write_en,
  output logic             o_executed,
  output logic [3:0]       o_flags,
  output logic             o_branch,
  output logic [WIDTH-1:0] o_branch_target
);

  state_t           state, state_nx;
  op_t              op;
  logic [3:0]       flags_ff;
  logic             mul_s;
  logic             accept, pass, is_mul, writes;
  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] rm_eff;
  logic             sh_c;
  logic [WIDTH-1:0] a, b, logic_res, alu_res;
  logic             cin, arith, ovf;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags, mul_flags;

  assign op        = op_t'(i_op);
  assign o_ready   = (state == ST_IDLE) && (!o_valid || i_ready);
  assign accept    = i_valid && o_ready;
  assign pass      = cond_pass(i_cc, flags_ff);
  assign is_mul    = (op == OP_MUL) || (op == OP_MLA);
  assign mul_start = accept && pass && is_mul && !i_clear;

  assign rm_eff = i_rrx ? {flags_ff[FLAG_C], i_rm[WIDTH-1:1]} : i_rm;
  assign sh_c   = i_rrx ? i_rm[0] : i_shift_carry;

  // Operand selection for the adder and the logical result.
  always_comb begin
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    arith     = 1'b0;
    logic_res = '0;
    case (op)
      OP_AND, OP_TST: logic_res = i_rn & rm_eff;
      OP_EOR, OP_TEQ: logic_res = i_rn ^ rm_eff;
      OP_ORR:         logic_res = i_rn | rm_eff;
      OP_BIC:         logic_res = i_rn & ~rm_eff;
      OP_MOV:         logic_res = rm_eff;
      OP_MVN:         logic_res = ~rm_eff;
      OP_SUB, OP_CMP: begin
        a = i_rn; b = ~rm_eff; cin = 1'b1; arith = 1'b1;
      end
      OP_RSB: begin
        a = rm_eff; b = ~i_rn; cin = 1'b1; arith = 1'b1;
      end
      OP_ADD, OP_CMN: begin
        a = i_rn; b = rm_eff; arith = 1'b1;
      end
      OP_ADC: begin
        a = i_rn; b = rm_eff; cin = flags_ff[FLAG_C]; arith = 1'b1;
      end
      OP_SBC: begin
        a = i_rn; b = ~rm_eff; cin = flags_ff[FLAG_C]; arith = 1'b1;
      end
      OP_RSC: begin
        a = rm_eff; b = ~i_rn; cin = flags_ff[FLAG_C]; arith = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign alu_res = arith ? sum[WIDTH-1:0] : logic_res;
  assign ovf     = (a[WIDTH-1] == b[WIDTH-1])
                && (sum[WIDTH-1] != a[WIDTH-1]);
  assign writes  = !((op == OP_TST) || (op == OP_TEQ)
                  || (op == OP_CMP) || (op == OP_CMN));

  assign alu_flags = {alu_res[WIDTH-1], alu_res == '0,
                      arith ? sum[WIDTH] : sh_c,
                      arith ? ovf : flags_ff[FLAG_V]};
  assign mul_flags = {mul_res[WIDTH-1], mul_res == '0,
                      flags_ff[FLAG_C], flags_ff[FLAG_V]};

  zap_alu_iter_mul #(
    .WIDTH    (WIDTH),
    .MUL_STEP (MUL_STEP)
  ) u_mul (
    .clk      (i_clk),
    .rst_n    (i_reset_n),
    .clear    (i_clear),
    .start    (mul_start),
    .run      (state == ST_MUL),
    .mcand    (i_rm),
    .mplier   (i_rn),
    .acc_init ((op == OP_MLA) ? i_acc : '0),
    .done     (mul_done),
    .result   (mul_res)
  );

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= state_nx;
  end

  // Next state: a flush always returns to IDLE.
  always_comb begin
    state_nx = state;
    if (i_clear) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (mul_start) state_nx = ST_MUL;
        ST_MUL:  if (mul_done)  state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // Output register, flags and pending multiply S bit.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_dest_index <= '0;
      o_write_en   <= 1'b0;
      o_executed   <= 1'b0;
      flags_ff     <= '0;
      mul_s        <= 1'b0;
    end else if (i_clear) begin
      o_valid  <= 1'b0;
      flags_ff <= i_clear_flags;
    end else if (state == ST_MUL) begin
      if (mul_done) begin
        o_valid  <= 1'b1;
        o_result <= mul_res;
        if (mul_s) flags_ff <= mul_flags;
      end
    end else if (accept) begin
      o_dest_index <= i_dest_index;
      o_executed   <= pass;
      o_write_en   <= pass && (is_mul || writes);
      if (!pass) begin
        o_valid  <= 1'b1;
        o_result <= '0;
      end else if (is_mul) begin
        o_valid <= 1'b0;
        mul_s   <= i_flag_update;
      end else begin
        o_valid  <= 1'b1;
        o_result <= alu_res;
        if (i_flag_update) flags_ff <= alu_flags;
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_flags  = flags_ff;
  assign o_branch = o_valid && o_write_en
                 && (o_dest_index == IDX_W'(PC_INDEX));
  assign o_branch_target = o_branch ? o_result : '0;

endmodule

// File: tb/tb_zap_alu_pipe.sv
// tb_zap_alu_pipe: directed vectors with a scoreboard queue and a
// negedge monitor that checks every transferred result.
`timescale 1ns/1ps
module tb_zap_alu_pipe;
  import zap_alu_pkg::*;

  logic        clk, rst_n;
  logic        i_clear;
  logic [3:0]  i_clear_flags;
  logic        i_valid, o_ready;
  logic [4:0]  i_op;
  logic [3:0]  i_cc;
  logic        i_flag_update, i_rrx, i_shift_carry;
  logic [31:0] i_rn, i_rm, i_acc;
  logic [5:0]  i_dest_index;
  logic        o_valid, i_ready;
  logic [31:0] o_result;
  logic [5:0]  o_dest_index;
  logic        o_write_en, o_executed;
  logic [3:0]  o_flags;
  logic        o_branch;
  logic [31:0] o_branch_target;

  typedef struct {
    logic [31:0] result;
    logic [5:0]  dest;
    logic        we;
    logic        ex;
    logic [3:0]  flags;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  logic exp_br, ok, mon_en;
  int   vectors = 0;
  int   miscompares = 0;

  zap_alu_pipe dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_clear         (i_clear),
    .i_clear_flags   (i_clear_flags),
    .i_valid         (i_valid),
    .o_ready         (o_ready),
    .i_op            (i_op),
    .i_cc            (i_cc),
    .i_flag_update   (i_flag_update),
    .i_rrx           (i_rrx),
    .i_shift_carry   (i_shift_carry),
    .i_rn            (i_rn),
    .i_rm            (i_rm),
    .i_acc           (i_acc),
    .i_dest_index    (i_dest_index),
    .o_valid         (o_valid),
    .i_ready         (i_ready),
    .o_result        (o_result),
    .o_dest_index    (o_dest_index),
    .o_write_en      (o_write_en),
    .o_executed      (o_executed),
    .o_flags         (o_flags),
    .o_branch        (o_branch),
    .o_branch_target (o_branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every transfer pops one expected entry.
  always @(negedge clk) begin
    if (mon_en && rst_n && o_valid && i_ready) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output res=%h dest=%0d",
                 o_result, o_dest_index);
      end else begin
        e_mon  = sb.pop_front();
        exp_br = e_mon.we && (e_mon.dest == 6'd15);
        ok = (o_dest_index == e_mon.dest)
          && (o_write_en == e_mon.we)
          && (o_executed == e_mon.ex)
          && (o_flags == e_mon.flags)
          && (!e_mon.ex || o_result == e_mon.result)
          && (o_branch == exp_br)
          && (o_branch_target == (exp_br ? e_mon.result : 32'h0));
        if (!ok) begin
          miscompares++;
          $display({"FAIL out_d%0d res=%h/%h we=%b/%b ex=%b/%b",
                    " flags=%b/%b br=%b/%b tgt=%h (actual/required)"},
                   e_mon.dest, o_result, e_mon.result,
                   o_write_en, e_mon.we, o_executed, e_mon.ex,
                   o_flags, e_mon.flags, o_branch, exp_br,
                   o_branch_target);
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] cc,
                       input logic s, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [31:0] acc,
                       input logic [5:0] dest, input logic rrx,
                       input logic shc);
    i_valid       = 1'b1;
    i_op          = op;
    i_cc          = cc;
    i_flag_update = s;
    i_rn          = rn;
    i_rm          = rm;
    i_acc         = acc;
    i_dest_index  = dest;
    i_rrx         = rrx;
    i_shift_carry = shc;
  endtask

  task automatic expect_out(input logic [31:0] res, input logic [5:0] dest,
                            input logic we, input logic ex,
                            input logic [3:0] fl);
    exp_t e;
    e.result = res;
    e.dest   = dest;
    e.we     = we;
    e.ex     = ex;
    e.flags  = fl;
    sb.push_back(e);
  endtask

  task automatic wait_accept(output int cycles);
    logic rdy;
    rdy    = 1'b0;
    cycles = 0;
    while (!rdy) begin
      @(negedge clk);
      rdy = o_ready;
      @(posedge clk);
      cycles++;
      if (!rdy && cycles > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout actual=stalled required=accept");
        rdy = 1'b1;
      end
    end
    #1 i_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_ready && n < 100);
    check("ready_timeout", 64'(o_ready), 64'(1'b1));
    @(posedge clk);
    #1;
  endtask

  int   cyc;
  logic seen;

  initial begin
    mon_en = 1'b0;
    rst_n  = 1'b0;
    i_clear = 1'b0;
    i_clear_flags = 4'h0;
    i_ready = 1'b1;
    drive(OP_AND, CC_AL, 1'b0, 32'h0, 32'h0, 32'h0, 6'd0, 1'b0, 1'b0);
    i_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({o_valid, o_flags, o_result}), 64'h0);
    rst_n = 1'b1;
    #1;
    check("reset_ready", 64'(o_ready), 64'(1'b1));
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow into sign bit, result valid one cycle after accept
    drive(OP_ADD, CC_AL, 1'b1, 32'h7FFFFFFF, 32'h1, 32'h0, 6'd1, 1'b0, 1'b0);
    expect_out(32'h80000000, 6'd1, 1'b1, 1'b1, 4'b1001);
    wait_accept(cyc);
    @(negedge clk);
    check("add_latency", 64'(o_valid), 64'(1'b1));
    @(posedge clk);
    #1;

    // SUB to zero then conditional MOV to PC
    drive(OP_SUB, CC_AL, 1'b1, 32'h5, 32'h5, 32'h0, 6'd2, 1'b0, 1'b0);
    expect_out(32'h0, 6'd2, 1'b1, 1'b1, 4'b0110);
    wait_accept(cyc);
    drive(OP_MOV, CC_EQ, 1'b0, 32'h0, 32'h1000, 32'h0, 6'd15, 1'b0, 1'b0);
    expect_out(32'h1000, 6'd15, 1'b1, 1'b1, 4'b0110);
    wait_accept(cyc);

    // Condition failures: NE with Z set, and NV
    drive(OP_ADD, CC_NE, 1'b1, 32'h1, 32'h2, 32'h0, 6'd3, 1'b0, 1'b0);
    expect_out(32'h0, 6'd3, 1'b0, 1'b0, 4'b0110);
    wait_accept(cyc);
    drive(OP_MOV, CC_NV, 1'b1, 32'h0, 32'h5, 32'h0, 6'd4, 1'b0, 1'b0);
    expect_out(32'h0, 6'd4, 1'b0, 1'b0, 4'b0110);
    wait_accept(cyc);

    // RRX MOVS with C=1, carry out from rm[0]
    drive(OP_MOV, CC_AL, 1'b1, 32'h0, 32'h2, 32'h0, 6'd5, 1'b1, 1'b1);
    expect_out(32'h80000001, 6'd5, 1'b1, 1'b1, 4'b1000);
    wait_accept(cyc);
    drive(OP_EOR, CC_AL, 1'b1, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h0, 6'd6,
          1'b0, 1'b1);
    expect_out(32'h0, 6'd6, 1'b1, 1'b1, 4'b0110);
    wait_accept(cyc);
    drive(OP_SBC, CC_AL, 1'b1, 32'h3, 32'h5, 32'h0, 6'd7, 1'b0, 1'b0);
    expect_out(32'hFFFFFFFE, 6'd7, 1'b1, 1'b1, 4'b1000);
    wait_accept(cyc);
    drive(OP_RSC, CC_AL, 1'b1, 32'h1, 32'hA, 32'h0, 6'd8, 1'b0, 1'b0);
    expect_out(32'h8, 6'd8, 1'b1, 1'b1, 4'b0010);
    wait_accept(cyc);
    drive(OP_CMP, CC_AL, 1'b1, 32'h80000000, 32'h1, 32'h0, 6'd9, 1'b0, 1'b0);
    expect_out(32'h7FFFFFFF, 6'd9, 1'b0, 1'b1, 4'b0011);
    wait_accept(cyc);
    drive(OP_ADD, CC_AL, 1'b1, 32'h80000000, 32'h80000000, 32'h0, 6'd10,
          1'b0, 1'b0);
    expect_out(32'h0, 6'd10, 1'b1, 1'b1, 4'b0111);
    wait_accept(cyc);

    // MULS: ready low for WIDTH/MUL_STEP cycles, C/V preserved
    drive(OP_MUL, CC_AL, 1'b1, 32'hFFFF, 32'h10001, 32'h0, 6'd11, 1'b0, 1'b0);
    expect_out(32'hFFFFFFFF, 6'd11, 1'b1, 1'b1, 4'b1011);
    wait_accept(cyc);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (o_ready) break;
      cyc++;
    end
    check("mul_busy_cycles", 64'(cyc), 64'd8);
    @(posedge clk);
    #1;

    drive(OP_MLA, CC_AL, 1'b0, 32'h3, 32'h5, 32'h7, 6'd12, 1'b0, 1'b0);
    expect_out(32'h16, 6'd12, 1'b1, 1'b1, 4'b1011);
    wait_accept(cyc);
    wait_ready();

    // Backpressure with a queued instruction
    i_ready = 1'b0;
    drive(OP_ADD, CC_AL, 1'b0, 32'h10, 32'h20, 32'h0, 6'd13, 1'b0, 1'b0);
    expect_out(32'h30, 6'd13, 1'b1, 1'b1, 4'b1011);
    wait_accept(cyc);
    drive(OP_ORR, CC_AL, 1'b0, 32'h0F, 32'hF0, 32'h0, 6'd14, 1'b0, 1'b0);
    expect_out(32'hFF, 6'd14, 1'b1, 1'b1, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 64'({o_valid, o_ready, o_flags, o_result}),
            64'({1'b1, 1'b0, 4'b1011, 32'h30}));
    end
    @(posedge clk);
    #1 i_ready = 1'b1;
    wait_accept(cyc);
    check("bp_accept_same_cycle", 64'(cyc), 64'd1);

    // Flush in the third cycle of a multiply
    drive(OP_MUL, CC_AL, 1'b1, 32'h12, 32'h34, 32'h0, 6'd16, 1'b0, 1'b0);
    wait_accept(cyc);
    repeat (2) @(posedge clk);
    #1;
    i_clear = 1'b1;
    i_clear_flags = 4'b0100;
    @(posedge clk);
    #1 i_clear = 1'b0;
    check("clear_state", 64'({o_valid, o_ready, o_flags}),
          64'({1'b0, 1'b1, 4'b0100}));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    check("clear_no_result", 64'(seen), 64'(1'b0));
    @(posedge clk);
    #1;

    // EQ passes only if the flush loaded Z
    drive(OP_ADD, CC_EQ, 1'b1, 32'hFFFFFFFF, 32'h3, 32'h0, 6'd17, 1'b0, 1'b0);
    expect_out(32'h2, 6'd17, 1'b1, 1'b1, 4'b0010);
    wait_accept(cyc);

    // Asynchronous reset in the middle of a multiply
    drive(OP_MUL, CC_AL, 1'b1, 32'h7, 32'h9, 32'h0, 6'd18, 1'b0, 1'b0);
    wait_accept(cyc);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset",
          64'({o_valid, o_flags, o_dest_index, o_result}), 64'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'(o_ready), 64'(1'b1));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen = seen | o_valid;
    end
    check("reset_no_result", 64'(seen), 64'(1'b0));
    @(posedge clk);
    #1;

    drive(OP_ADD, CC_AL, 1'b0, 32'h2, 32'h3, 32'h0, 6'd19, 1'b0, 1'b0);
    expect_out(32'h5, 6'd19, 1'b1, 1'b1, 4'b0000);
    wait_accept(cyc);
    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
